tblink_rpc_invoke_initiator: RTL and testbench

//  HDL-side initiator for TbLink RPC invokes; the calling end of the invoke/invoke_rsp exchange.

---
 rtl/tblink_rpc_invoke_initiator.sv | 228 ++++++++++++++++++++++
 tb/tb_tblink_rpc_invoke_initiator.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tblink_rpc_invoke_initiator.sv
// tblink_rpc_invoke_initiator: calling end of the TbLink RPC invoke/invoke_rsp exchange.
// Serialises calls onto a word stream, tracks outstanding call ids and turns matched responses into completions.
module tblink_rpc_invoke_initiator #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned METHOD_W    = 8,
   parameter int unsigned CALL_ID_W   = 8,
   parameter int unsigned MAX_PARAMS  = 4,
   parameter int unsigned OUTSTANDING = 4
) (
   input  logic                               clock,
   input  logic                               reset_n,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [METHOD_W-1:0]                req_method,
   input  logic [7:0]                         req_nparams,
   input  logic [MAX_PARAMS*DATA_W-1:0]       req_params,
   output logic [CALL_ID_W-1:0]               req_call_id,
   output logic                               tx_valid,
   input  logic                               tx_ready,
   output logic [DATA_W-1:0]                  tx_data,
   output logic                               tx_last,
   input  logic                               rx_valid,
   output logic                               rx_ready,
   input  logic [CALL_ID_W-1:0]               rx_call_id,
   input  logic [DATA_W-1:0]                  rx_retval,
   output logic                               cpl_valid,
   input  logic                               cpl_ready,
   output logic [METHOD_W-1:0]                cpl_method,
   output logic [CALL_ID_W-1:0]               cpl_call_id,
   output logic [DATA_W-1:0]                  cpl_retval,
   output logic                               err_unknown_id,
   output logic [$clog2(OUTSTANDING+1)-1:0]   outstanding
);

   localparam int unsigned CNT_W  = $clog2(OUTSTANDING + 1);
   localparam int unsigned IDX_W  = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;
   localparam int unsigned SLOT_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int unsigned HDR_HI = CALL_ID_W + METHOD_W + 8;

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PARAM} state_e;

   state_e                        state_q, state_d;
   logic                          run_q;
   logic [CALL_ID_W-1:0]          id_cnt_q, id_cnt_d;
   logic [CALL_ID_W-1:0]          call_id_q, call_id_d;
   logic [METHOD_W-1:0]           method_q, method_d;
   logic [7:0]                    nparams_q, nparams_d;
   logic [MAX_PARAMS*DATA_W-1:0]  params_q, params_d;
   logic [IDX_W-1:0]              idx_q, idx_d;

   logic [OUTSTANDING-1:0]        slot_vld_q, slot_vld_d;
   logic [CALL_ID_W-1:0]          slot_id_q     [OUTSTANDING];
   logic [CALL_ID_W-1:0]          slot_id_d     [OUTSTANDING];
   logic [METHOD_W-1:0]           slot_method_q [OUTSTANDING];
   logic [METHOD_W-1:0]           slot_method_d [OUTSTANDING];
   logic [CNT_W-1:0]              out_cnt_q, out_cnt_d;

   logic                          cpl_valid_q, cpl_valid_d;
   logic [METHOD_W-1:0]           cpl_method_q, cpl_method_d;
   logic [CALL_ID_W-1:0]          cpl_call_id_q, cpl_call_id_d;
   logic [DATA_W-1:0]             cpl_retval_q, cpl_retval_d;
   logic                          err_q, err_d;

   logic                          full_c, id_busy_c, hit_c;
   logic [SLOT_W-1:0]             hit_idx_c, free_idx_c;
   logic                          req_fire_c, rx_fire_c, rx_hit_c;
   logic [7:0]                    nparams_clamp_c;
   logic [DATA_W-1:0]             hdr_word_c, param_word_c;

   // Associative search of the call table: free slot, counter-id collision, response match
   always_comb begin
      full_c     = (out_cnt_q == CNT_W'(OUTSTANDING));
      id_busy_c  = 1'b0;
      hit_c      = 1'b0;
      hit_idx_c  = '0;
      free_idx_c = '0;
      for (int i = 0; i < int'(OUTSTANDING); i++) begin
         if (!slot_vld_q[i]) free_idx_c = SLOT_W'(i);
         if (slot_vld_q[i] && (slot_id_q[i] == id_cnt_q)) id_busy_c = 1'b1;
         if (slot_vld_q[i] && (slot_id_q[i] == rx_call_id)) begin
            hit_c     = 1'b1;
            hit_idx_c = SLOT_W'(i);
         end
      end
   end

   assign req_ready       = run_q && (state_q == ST_IDLE) && !full_c && !id_busy_c;
   assign req_call_id     = id_cnt_q;
   assign req_fire_c      = req_valid && req_ready;
   assign rx_ready        = run_q && (!cpl_valid_q || cpl_ready);
   assign rx_fire_c       = rx_valid && rx_ready;
   assign rx_hit_c        = rx_fire_c && hit_c;
   assign nparams_clamp_c = (req_nparams > 8'(MAX_PARAMS)) ? 8'(MAX_PARAMS) : req_nparams;

   // Outbound word formatting from the latched call
   always_comb begin
      param_word_c = '0;
      for (int i = 0; i < int'(MAX_PARAMS); i++) begin
         if (idx_q == IDX_W'(i)) param_word_c = params_q[i*DATA_W +: DATA_W];
      end
      hdr_word_c                          = '0;
      hdr_word_c[7:0]                     = nparams_q;
      hdr_word_c[METHOD_W+7:8]            = method_q;
      hdr_word_c[HDR_HI-1:METHOD_W+8]     = call_id_q;
   end

   assign tx_valid = (state_q != ST_IDLE);
   assign tx_data  = (state_q == ST_HDR)   ? hdr_word_c :
                     (state_q == ST_PARAM) ? param_word_c : '0;
   assign tx_last  = (state_q == ST_HDR)   ? (nparams_q == 8'd0) :
                     (state_q == ST_PARAM) ? (8'(idx_q) == (nparams_q - 8'd1)) : 1'b0;

   // Call sequencer: IDLE -> HDR -> PARAM* -> IDLE
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      method_d  = method_q;
      nparams_d = nparams_q;
      params_d  = params_q;
      call_id_d = call_id_q;
      id_cnt_d  = id_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_fire_c) begin
               method_d  = req_method;
               nparams_d = nparams_clamp_c;
               params_d  = req_params;
               call_id_d = id_cnt_q;
               id_cnt_d  = id_cnt_q + CALL_ID_W'(1);
               state_d   = ST_HDR;
            end
         end
         ST_HDR: begin
            if (tx_ready) begin
               idx_d   = '0;
               state_d = (nparams_q == 8'd0) ? ST_IDLE : ST_PARAM;
            end
         end
         ST_PARAM: begin
            if (tx_ready) begin
               idx_d = idx_q + IDX_W'(1);
               if (tx_last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Table allocate/free and completion staging; alloc and free may coincide
   always_comb begin
      slot_vld_d    = slot_vld_q;
      slot_id_d     = slot_id_q;
      slot_method_d = slot_method_q;
      cpl_valid_d   = cpl_valid_q;
      cpl_method_d  = cpl_method_q;
      cpl_call_id_d = cpl_call_id_q;
      cpl_retval_d  = cpl_retval_q;
      err_d         = rx_fire_c && !hit_c;
      if (cpl_ready) cpl_valid_d = 1'b0;
      if (rx_hit_c) begin
         slot_vld_d[hit_idx_c] = 1'b0;
         cpl_valid_d           = 1'b1;
         cpl_method_d          = slot_method_q[hit_idx_c];
         cpl_call_id_d         = rx_call_id;
         cpl_retval_d          = rx_retval;
      end
      if (req_fire_c) begin
         slot_vld_d[free_idx_c]    = 1'b1;
         slot_id_d[free_idx_c]     = id_cnt_q;
         slot_method_d[free_idx_c] = req_method;
      end
      case ({req_fire_c, rx_hit_c})
         2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
         2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
         default: out_cnt_d = out_cnt_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         run_q         <= 1'b0;
         id_cnt_q      <= '0;
         call_id_q     <= '0;
         method_q      <= '0;
         nparams_q     <= '0;
         params_q      <= '0;
         idx_q         <= '0;
         slot_vld_q    <= '0;
         out_cnt_q     <= '0;
         cpl_valid_q   <= 1'b0;
         cpl_method_q  <= '0;
         cpl_call_id_q <= '0;
         cpl_retval_q  <= '0;
         err_q         <= 1'b0;
         for (int i = 0; i < int'(OUTSTANDING); i++) begin
            slot_id_q[i]     <= '0;
            slot_method_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         run_q         <= 1'b1;
         id_cnt_q      <= id_cnt_d;
         call_id_q     <= call_id_d;
         method_q      <= method_d;
         nparams_q     <= nparams_d;
         params_q      <= params_d;
         idx_q         <= idx_d;
         slot_vld_q    <= slot_vld_d;
         out_cnt_q     <= out_cnt_d;
         cpl_valid_q   <= cpl_valid_d;
         cpl_method_q  <= cpl_method_d;
         cpl_call_id_q <= cpl_call_id_d;
         cpl_retval_q  <= cpl_retval_d;
         err_q         <= err_d;
         slot_id_q     <= slot_id_d;
         slot_method_q <= slot_method_d;
      end
   end

   assign cpl_valid      = cpl_valid_q;
   assign cpl_method     = cpl_method_q;
   assign cpl_call_id    = cpl_call_id_q;
   assign cpl_retval     = cpl_retval_q;
   assign err_unknown_id = err_q;
   assign outstanding    = out_cnt_q;

endmodule

// File: tb/tb_tblink_rpc_invoke_initiator.sv
// Bench for tblink_rpc_invoke_initiator: transaction-level model checked every cycle, plus directed literals.
module tb_tblink_rpc_invoke_initiator;

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;

   logic          req_valid, req_ready, tx_valid, tx_ready, tx_last;
   logic [7:0]    req_method, req_nparams, req_call_id;
   logic [127:0]  req_params;
   logic [31:0]   tx_data, rx_retval, cpl_retval;
   logic          rx_valid, rx_ready, cpl_valid, cpl_ready, err_unknown_id;
   logic [7:0]    rx_call_id, cpl_method, cpl_call_id;
   logic [2:0]    outstanding;

   logic          req_valid2, req_ready2, tx_valid2, tx_ready2, tx_last2;
   logic [7:0]    req_method2, req_nparams2, cpl_method2;
   logic [127:0]  req_params2;
   logic [1:0]    req_call_id2, rx_call_id2, cpl_call_id2;
   logic [31:0]   tx_data2, rx_retval2, cpl_retval2;
   logic          rx_valid2, rx_ready2, cpl_valid2, cpl_ready2, err2;
   logic [2:0]    outstanding2;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   tblink_rpc_invoke_initiator dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_method(req_method),
      .req_nparams(req_nparams), .req_params(req_params), .req_call_id(req_call_id),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_call_id(rx_call_id), .rx_retval(rx_retval),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_method(cpl_method),
      .cpl_call_id(cpl_call_id), .cpl_retval(cpl_retval),
      .err_unknown_id(err_unknown_id), .outstanding(outstanding));

   tblink_rpc_invoke_initiator #(.CALL_ID_W(2)) dut2 (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_method(req_method2),
      .req_nparams(req_nparams2), .req_params(req_params2), .req_call_id(req_call_id2),
      .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data2), .tx_last(tx_last2),
      .rx_valid(rx_valid2), .rx_ready(rx_ready2), .rx_call_id(rx_call_id2), .rx_retval(rx_retval2),
      .cpl_valid(cpl_valid2), .cpl_ready(cpl_ready2), .cpl_method(cpl_method2),
      .cpl_call_id(cpl_call_id2), .cpl_retval(cpl_retval2),
      .err_unknown_id(err2), .outstanding(outstanding2));

   // Transaction model of the default-parameter instance
   bit            m_run;
   logic [32:0]   m_txq[$];
   int            m_tab[int];
   int            m_next;
   bit            m_cv, m_err;
   logic [7:0]    m_cm, m_cid;
   logic [31:0]   m_cr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_req_ready();
      return m_run && (m_txq.size() == 0) && (m_tab.num() < 4) && !m_tab.exists(m_next);
   endfunction

   function automatic bit exp_rx_ready();
      return m_run && (!m_cv || cpl_ready);
   endfunction

   task automatic model_reset();
      m_run = 1'b0; m_txq.delete(); m_tab.delete(); m_next = 0;
      m_cv = 1'b0; m_err = 1'b0; m_cm = '0; m_cid = '0; m_cr = '0;
   endtask

   task automatic model_update();
      bit ra, ta, xa;
      int id, n;
      if (!reset_n) begin
         model_reset();
         return;
      end
      ra = req_valid && exp_req_ready();
      ta = (m_txq.size() != 0) && tx_ready;
      xa = rx_valid && exp_rx_ready();
      m_err = 1'b0;
      if (cpl_ready) m_cv = 1'b0;
      if (xa) begin
         id = int'(rx_call_id);
         if (m_tab.exists(id)) begin
            m_cv = 1'b1; m_cm = 8'(m_tab[id]); m_cid = rx_call_id; m_cr = rx_retval;
            m_tab.delete(id);
         end else m_err = 1'b1;
      end
      if (ta) void'(m_txq.pop_front());
      if (ra) begin
         n = (int'(req_nparams) > 4) ? 4 : int'(req_nparams);
         m_txq.push_back({1'(n == 0), 32'(m_next * 65536 + int'(req_method) * 256 + n)});
         for (int i = 0; i < n; i++) m_txq.push_back({1'(i == n - 1), req_params[i*32 +: 32]});
         m_tab[m_next] = int'(req_method);
         m_next = (m_next + 1) % 256;
      end
      m_run = 1'b1;
   endtask

   task automatic compare_all();
      logic [32:0] f;
      chk("req_ready", 64'(req_ready), 64'(exp_req_ready()));
      chk("req_call_id", 64'(req_call_id), 64'(8'(m_next)));
      chk("tx_valid", 64'(tx_valid), 64'(m_txq.size() != 0));
      if (m_txq.size() != 0) begin
         f = m_txq[0];
         chk("tx_data", 64'(tx_data), 64'(f[31:0]));
         chk("tx_last", 64'(tx_last), 64'(f[32]));
      end
      chk("rx_ready", 64'(rx_ready), 64'(exp_rx_ready()));
      chk("cpl_valid", 64'(cpl_valid), 64'(m_cv));
      if (m_cv) begin
         chk("cpl_method", 64'(cpl_method), 64'(m_cm));
         chk("cpl_call_id", 64'(cpl_call_id), 64'(m_cid));
         chk("cpl_retval", 64'(cpl_retval), 64'(m_cr));
      end
      chk("err_unknown_id", 64'(err_unknown_id), 64'(m_err));
      chk("outstanding", 64'(outstanding), 64'(m_tab.num()));
   endtask

   // One clock: model follows the active edge, outputs compared on the falling edge
   task automatic step();
      @(posedge clock);
      model_update();
      @(negedge clock);
      compare_all();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step(); step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!req_ready && n < 20) begin step(); n++; end
      chk("req_ready_wait", 64'(req_ready), 64'd1);
   endtask

   task automatic wait_rdy2();
      int n = 0;
      while (!req_ready2 && n < 20) begin step(); n++; end
      chk("req_ready2_wait", 64'(req_ready2), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ew[3];
      logic        el[3];
      model_reset();
      req_valid = 0; req_method = 0; req_nparams = 0; req_params = '0;
      tx_ready = 1; rx_valid = 0; rx_call_id = 0; rx_retval = 0; cpl_ready = 1;
      req_valid2 = 0; req_method2 = 0; req_nparams2 = 0; req_params2 = '0;
      tx_ready2 = 1; rx_valid2 = 0; rx_call_id2 = 0; rx_retval2 = 0; cpl_ready2 = 1;
      #2;
      do_reset();
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_cpl_valid", 64'(cpl_valid), 64'd0);

      // Zero-param call: single header beat
      req_valid = 1; req_method = 8'd3; req_nparams = 8'd0;
      step();
      req_valid = 0;
      chk("t1_tx_data", 64'(tx_data), 64'h0000_0300);
      chk("t1_tx_last", 64'(tx_last), 64'd1);
      chk("t1_outstanding", 64'(outstanding), 64'd1);
      chk("t1_req_call_id", 64'(req_call_id), 64'd1);
      step();
      rx_valid = 1; rx_call_id = 8'd0; rx_retval = 32'hC0FF_EE01;
      step();
      rx_valid = 0;
      chk("t1_cpl_valid", 64'(cpl_valid), 64'd1);
      chk("t1_cpl_method", 64'(cpl_method), 64'd3);
      chk("t1_cpl_retval", 64'(cpl_retval), 64'hC0FF_EE01);
      step();

      // Two-param call from id 0
      do_reset();
      req_valid = 1; req_method = 8'd5; req_nparams = 8'd2;
      req_params = {64'd0, 32'hBBBB_0002, 32'hAAAA_0001};
      ew[0] = 32'h0000_0502; ew[1] = 32'hAAAA_0001; ew[2] = 32'hBBBB_0002;
      el[0] = 1'b0; el[1] = 1'b0; el[2] = 1'b1;
      step();
      req_valid = 0;
      for (int k = 0; k < 3; k++) begin
         chk("t2_tx_data", 64'(tx_data), 64'(ew[k]));
         chk("t2_tx_last", 64'(tx_last), 64'(el[k]));
         step();
      end
      chk("t2_tx_idle", 64'(tx_valid), 64'd0);

      // nparams clamped to 4, with tx backpressure
      tx_ready = 0;
      req_valid = 1; req_method = 8'd9; req_nparams = 8'd7;
      req_params = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
      step();
      req_valid = 0;
      chk("t2_clamp_hdr", 64'(tx_data), 64'h0001_0904);
      for (int k = 0; k < 10; k++) begin
         tx_ready = (k % 3 != 0);
         step();
      end
      tx_ready = 1;
      repeat (6) step();

      // Fill the table, then free one slot
      do_reset();
      for (int k = 0; k < 4; k++) begin
         wait_rdy();
         req_valid = 1; req_method = 8'(8'h10 + k); req_nparams = 8'd1;
         req_params = {96'd0, 32'(32'h5000_0000 + k)};
         step();
         req_valid = 0;
         step(); step();
      end
      chk("t3_full_ready", 64'(req_ready), 64'd0);
      chk("t3_full_count", 64'(outstanding), 64'd4);
      chk("t3_next_id", 64'(req_call_id), 64'd4);
      rx_valid = 1; rx_call_id = 8'd2; rx_retval = 32'h2222_2222;
      step();
      rx_valid = 0;
      chk("t3_cpl_method", 64'(cpl_method), 64'h12);
      chk("t3_cpl_id", 64'(cpl_call_id), 64'd2);
      chk("t3_ready_after_free", 64'(req_ready), 64'd1);

      // Unknown id
      rx_valid = 1; rx_call_id = 8'h7F; rx_retval = 32'hDEAD_BEEF;
      step();
      rx_valid = 0;
      chk("t3_err", 64'(err_unknown_id), 64'd1);
      chk("t3_err_no_cpl", 64'(cpl_valid), 64'd0);
      chk("t3_err_count", 64'(outstanding), 64'd3);
      step();
      chk("t3_err_pulse", 64'(err_unknown_id), 64'd0);

      // Completion backpressure holds the second response
      cpl_ready = 0;
      rx_valid = 1; rx_call_id = 8'd0; rx_retval = 32'hAAAA_0000;
      step();
      rx_call_id = 8'd1; rx_retval = 32'hBBBB_0001;
      chk("t4_rx_blocked", 64'(rx_ready), 64'd0);
      step();
      chk("t4_first_held", 64'(cpl_retval), 64'hAAAA_0000);
      chk("t4_count_held", 64'(outstanding), 64'd2);
      cpl_ready = 1;
      step();
      rx_valid = 0;
      chk("t4_second", 64'(cpl_retval), 64'hBBBB_0001);
      chk("t4_second_id", 64'(cpl_call_id), 64'd1);
      step();

      // Same-cycle allocate and free
      rx_valid = 1; rx_call_id = 8'd3; rx_retval = 32'h3333_3333;
      req_valid = 1; req_method = 8'h44; req_nparams = 8'd0;
      step();
      rx_valid = 0; req_valid = 0;
      chk("t5_count_same", 64'(outstanding), 64'd1);
      chk("t5_cpl_id", 64'(cpl_call_id), 64'd3);
      step();

      // Response arrives while its own call is still streaming
      tx_ready = 0;
      req_valid = 1; req_method = 8'h66; req_nparams = 8'd4;
      req_params = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000};
      step();
      req_valid = 0;
      step();
      rx_valid = 1; rx_call_id = 8'd5; rx_retval = 32'h5555_5555;
      step();
      rx_valid = 0;
      chk("t6_cpl_id", 64'(cpl_call_id), 64'd5);
      chk("t6_cpl_method", 64'(cpl_method), 64'h66);
      chk("t6_hdr_stable", 64'(tx_data), 64'h0005_6604);
      tx_ready = 1;
      repeat (6) step();

      // Reset in the middle of the parameter stream
      req_valid = 1; req_method = 8'h77; req_nparams = 8'd3;
      step();
      req_valid = 0;
      step(); step();
      chk("t7_in_param", 64'(tx_valid), 64'd1);
      reset_n = 0;
      #1;
      chk("t7_rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("t7_rst_count", 64'(outstanding), 64'd0);
      chk("t7_rst_ready", 64'(req_ready), 64'd0);
      model_reset();
      step(); step();
      reset_n = 1;
      step();
      chk("t7_id_restart", 64'(req_call_id), 64'd0);
      chk("t7_ready", 64'(req_ready), 64'd1);

      // 2-bit ids: wrap onto a still-pending id stalls the next request
      for (int k = 0; k < 4; k++) begin
         wait_rdy2();
         req_valid2 = 1; req_method2 = 8'(k + 1);
         step();
         req_valid2 = 0;
         step();
      end
      for (int k = 1; k < 4; k++) begin
         rx_valid2 = 1; rx_call_id2 = 2'(k); rx_retval2 = 32'(k);
         step();
      end
      rx_valid2 = 0;
      step();
      chk("w_count", 64'(outstanding2), 64'd1);
      chk("w_next_id", 64'(req_call_id2), 64'd0);
      chk("w_stall", 64'(req_ready2), 64'd0);
      step(); step();
      chk("w_stall_hold", 64'(req_ready2), 64'd0);
      rx_valid2 = 1; rx_call_id2 = 2'd0; rx_retval2 = 32'h0000_00AA;
      step();
      rx_valid2 = 0;
      chk("w_cpl_id", 64'(cpl_call_id2), 64'd0);
      chk("w_cpl_method", 64'(cpl_method2), 64'd1);
      chk("w_released", 64'(req_ready2), 64'd1);
      chk("w_empty", 64'(outstanding2), 64'd0);
      req_valid2 = 1; req_method2 = 8'd9;
      step();
      req_valid2 = 0;
      chk("w_hdr", 64'(tx_data2), 64'h0000_0900);
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
